// File: rtl/tt_serial_word_tx.sv
// Serial word transmitter: a byte-addressed load buffer is shifted out LSB first
// on a single wire, one bit held for CYCLES_PER_BIT clocks, framed by o_ser_valid.
module tt_serial_word_tx #(
    parameter int WORD_BITS      = 64,
    parameter int CYCLES_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_data_in,
    input  logic [2:0] i_byte_idx,
    input  logic       i_wr_en,
    input  logic       i_start,
    output logic       o_ser_out,
    output logic       o_ser_valid,
    output logic       o_busy,
    output logic       o_done
);

    localparam int NUM_LANES = WORD_BITS / 8;
    localparam int BIT_W     = $clog2(WORD_BITS);

    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WORD_BITS - 1);
    localparam logic [7:0]       LAST_HOLD = 8'(CYCLES_PER_BIT - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]           r_state;
    logic [WORD_BITS-1:0] r_buf;
    logic [WORD_BITS-1:0] r_shift;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [7:0]           r_hold_cnt;
    logic                 r_ser_out;
    logic                 r_ser_valid;
    logic                 r_busy;
    logic                 r_done;

    logic [0:0]           w_state_nxt;
    logic [WORD_BITS-1:0] w_buf_nxt;
    logic [WORD_BITS-1:0] w_shift_nxt;
    logic [BIT_W-1:0]     w_bit_nxt;
    logic [7:0]           w_hold_nxt;
    logic                 w_done_nxt;

    // The buffer update is computed first so a write in the start cycle lands in the frame.
    always_comb begin
        w_buf_nxt = r_buf;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (i_wr_en && (r_state == ST_IDLE) && (i_byte_idx == 3'(l))) begin
                w_buf_nxt[l*8 +: 8] = i_data_in;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit_cnt;
        w_hold_nxt  = r_hold_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_SHIFT;
                    w_shift_nxt = w_buf_nxt;
                    w_bit_nxt   = '0;
                    w_hold_nxt  = '0;
                end
            end
            ST_SHIFT: begin
                if (r_hold_cnt == LAST_HOLD) begin
                    w_hold_nxt = '0;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_shift_nxt = {1'b0, r_shift[WORD_BITS-1:1]};
                        w_bit_nxt   = r_bit_cnt + 1'b1;
                    end
                end else begin
                    w_hold_nxt = r_hold_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_buf       <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_hold_cnt  <= '0;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_buf       <= w_buf_nxt;
            r_shift     <= w_shift_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_ser_out   <= (w_state_nxt == ST_SHIFT) & w_shift_nxt[0];
            r_ser_valid <= (w_state_nxt == ST_SHIFT);
            r_busy      <= (w_state_nxt == ST_SHIFT);
            r_done      <= w_done_nxt;
        end
    end

    assign o_ser_out   = r_ser_out;
    assign o_ser_valid = r_ser_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_tt_serial_word_tx.sv
// Directed bench for tt_serial_word_tx: one instance at one clock per bit,
// one at three clocks per bit, checked against hand-computed words.
module tb_tt_serial_word_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] data1, data3;
    logic [2:0] idx1, idx3;
    logic       wr1, wr3, start1, start3;
    logic       ser1, valid1, busy1, done1;
    logic       ser3, valid3, busy3, done3;

    int nChecks = 0;
    int nPass   = 0;

    tt_serial_word_tx #(.WORD_BITS(64), .CYCLES_PER_BIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_data_in(data1), .i_byte_idx(idx1), .i_wr_en(wr1),
        .i_start(start1), .o_ser_out(ser1), .o_ser_valid(valid1), .o_busy(busy1),
        .o_done(done1)
    );

    tt_serial_word_tx #(.WORD_BITS(64), .CYCLES_PER_BIT(3)) u_dut3 (
        .clk(clk), .rst(rst), .i_data_in(data3), .i_byte_idx(idx3), .i_wr_en(wr3),
        .i_start(start3), .o_ser_out(ser3), .o_ser_valid(valid3), .o_busy(busy3),
        .o_done(done3)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        nChecks++;
        if (observed === expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit sel3, input logic [2:0] idx, input logic [7:0] data);
        if (sel3) begin
            wr3 = 1'b1; idx3 = idx; data3 = data;
        end else begin
            wr1 = 1'b1; idx1 = idx; data1 = data;
        end
        @(posedge clk);
        #1;
        wr1 = 1'b0;
        wr3 = 1'b0;
    endtask

    // Starts a frame on the CPB=1 instance and captures it; optionally merges a write
    // with the start, and at bit injectAt either pulses reset or a dropped write+start.
    task automatic runFrame1(input string tag, input logic [63:0] expWord,
                             input bit withWrite, input logic [2:0] wIdx,
                             input logic [7:0] wData, input int injectAt,
                             input bit injectRst, output logic [63:0] got);
        int cnt;
        cnt = 0;
        got = '0;
        if (withWrite) begin
            wr1 = 1'b1; idx1 = wIdx; data1 = wData;
        end
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        wr1    = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (injectAt >= 0 && k == injectAt + 1) begin
                wr1    = 1'b0;
                start1 = 1'b0;
                if (injectRst) begin
                    rst = 1'b0;
                    checkOutput({tag, "_serOut"}, 64'(ser1), 64'd0);
                    checkOutput({tag, "_valid"}, 64'(valid1), 64'd0);
                    checkOutput({tag, "_busy"}, 64'(busy1), 64'd0);
                    checkOutput({tag, "_done"}, 64'(done1), 64'd0);
                    return;
                end
            end
            got[k] = ser1;
            if (valid1) cnt++;
            if (k == injectAt) begin
                if (injectRst) begin
                    rst = 1'b1;
                end else begin
                    wr1 = 1'b1; idx1 = 3'd0; data1 = 8'hFF; start1 = 1'b1;
                end
            end
        end
        @(negedge clk);
        checkOutput({tag, "_word"}, got, expWord);
        checkOutput({tag, "_validCycles"}, 64'(cnt), 64'd64);
        checkOutput({tag, "_done"}, 64'(done1), 64'd1);
        checkOutput({tag, "_validAfter"}, 64'(valid1), 64'd0);
        checkOutput({tag, "_busyAfter"}, 64'(busy1), 64'd0);
    endtask

    logic [7:0]  laneVals [8];
    logic [63:0] got;
    logic [63:0] word3;
    logic [8:0]  pat3;
    int          cntValid, cntOnes, cntDone;

    initial begin
        laneVals = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        rst = 1'b1;
        data1 = '0; idx1 = '0; wr1 = 1'b0; start1 = 1'b0;
        data3 = '0; idx3 = '0; wr3 = 1'b0; start3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_serOut", 64'(ser1), 64'd0);
        checkOutput("reset_valid", 64'(valid1), 64'd0);
        checkOutput("reset_busy", 64'(busy1), 64'd0);
        checkOutput("reset_done", 64'(done1), 64'd0);
        checkOutput("reset_valid3", 64'(valid3), 64'd0);

        runFrame1("zeroWord", 64'd0, 1'b0, 3'd0, 8'd0, -1, 1'b0, got);
        @(negedge clk);
        checkOutput("donePulseEnds", 64'(done1), 64'd0);

        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 3'(i), laneVals[i]);
        runFrame1("lanes", 64'hEFCDAB8967452301, 1'b0, 3'd0, 8'd0, -1, 1'b0, got);
        runFrame1("backToBack", 64'hEFCDAB8967452301, 1'b0, 3'd0, 8'd0, -1, 1'b0, got);
        runFrame1("mergedWrite", 64'h80CDAB8967452301, 1'b1, 3'd7, 8'h80, -1, 1'b0, got);
        checkOutput("mergedBit63", 64'(got[63]), 64'd1);

        runFrame1("midFrameIgnored", 64'h80CDAB8967452301, 1'b0, 3'd0, 8'd0, 10, 1'b0, got);
        @(negedge clk);
        checkOutput("noQueuedStart", 64'(busy1), 64'd0);
        runFrame1("droppedWrite", 64'h80CDAB8967452301, 1'b0, 3'd0, 8'd0, -1, 1'b0, got);

        runFrame1("rstMid", 64'd0, 1'b0, 3'd0, 8'd0, 20, 1'b1, got);
        cntDone = 0;
        cntValid = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done1) cntDone++;
            if (valid1) cntValid++;
        end
        checkOutput("rstNoDone", 64'(cntDone), 64'd0);
        checkOutput("rstNoValid", 64'(cntValid), 64'd0);
        runFrame1("afterReset", 64'd0, 1'b0, 3'd0, 8'd0, -1, 1'b0, got);

        // Slow instance: word 0x5 with each bit held three clocks.
        applyStimulus(1'b1, 3'd0, 8'h05);
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        word3 = '0; pat3 = '0;
        cntValid = 0; cntOnes = 0; cntDone = 0;
        for (int i = 0; i < 195; i++) begin
            @(negedge clk);
            if (i < 9) pat3[i] = ser3;
            if (i < 192 && (i % 3) == 1) word3[i/3] = ser3;
            if (valid3) cntValid++;
            if (ser3) cntOnes++;
            if (done3) cntDone++;
            if (i == 192) begin
                checkOutput("cpb3_doneAt193", 64'(done3), 64'd1);
                checkOutput("cpb3_validOff", 64'(valid3), 64'd0);
            end
        end
        checkOutput("cpb3_pattern", 64'(pat3), 64'h1C7);
        checkOutput("cpb3_word", word3, 64'h5);
        checkOutput("cpb3_validCycles", 64'(cntValid), 64'd192);
        checkOutput("cpb3_onesCycles", 64'(cntOnes), 64'd6);
        checkOutput("cpb3_donePulses", 64'(cntDone), 64'd1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
